// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner index, word width.
package dmem_arb_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  typedef logic owner_t;
endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t last,
  output owner_t grant,
  output logic   valid
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) grant = ~last;
    else              grant = req1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM (CPU = port 0, loader/debug = port 1).
// Optional upper-address range check is enabled with `define DMEM_ARB_RANGE_CHK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [WORD_W-1:0] addr0,
  input  logic [WORD_W-1:0] wdata0,
  output logic [WORD_W-1:0] rdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [WORD_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata1,
  output logic [WORD_W-1:0] rdata1,
  output logic              ack1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              err
);

  state_t            state;
  owner_t            grant, owner, last;
  logic              valid;
  logic              sel_we, range_bad, rd_q, range_q, resp_rd;
  logic [WORD_W-1:0] sel_addr, sel_wdata, rdata_now, hold0, hold1;
  logic [1:0]        cnt;
  logic              unused_bits;

  rr_arb2 u_rr (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .grant (grant),
    .valid (valid)
  );

  assign sel_we    = grant ? we1    : we0;
  assign sel_addr  = grant ? addr1  : addr0;
  assign sel_wdata = grant ? wdata1 : wdata0;

`ifdef DMEM_ARB_RANGE_CHK_EN
  assign range_bad   = |sel_addr[WORD_W-1:ADDR_W+2];
  assign unused_bits = ^sel_addr[1:0];
`else
  assign range_bad   = 1'b0;
  assign unused_bits = ^{sel_addr[WORD_W-1:ADDR_W+2], sel_addr[1:0]};
`endif

  // Read data reaches the owner straight from the RAM in the RESP cycle; otherwise the
  // last value delivered to that port is held.
  assign rdata_now = range_q ? '0 : mem_rdata;
  assign resp_rd   = (state == RESP) && (rd_q || range_q);
  assign rdata0    = (resp_rd && owner == 1'b0) ? rdata_now : hold0;
  assign rdata1    = (resp_rd && owner == 1'b1) ? rdata_now : hold1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      rd_q      <= 1'b0;
      range_q   <= 1'b0;
      cnt       <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hold0     <= '0;
      hold1     <= '0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err    <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            owner     <= grant;
            rd_q      <= ~sel_we;
            range_q   <= range_bad;
            mem_addr  <= sel_addr[ADDR_W+1:2];
            mem_wdata <= sel_wdata;
            mem_en    <= ~range_bad;
            mem_we    <= sel_we & ~range_bad;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!rd_q || range_q || RD_LAT <= 1) begin
            ack0  <= (owner == 1'b0);
            ack1  <= (owner == 1'b1);
            err   <= range_q;
            state <= RESP;
          end else begin
            cnt   <= 2'(RD_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            ack0  <= (owner == 1'b0);
            ack1  <= (owner == 1'b1);
            state <= RESP;
          end
        end
        RESP: begin
          if (rd_q || range_q) begin
            if (owner == 1'b0) hold0 <= rdata_now;
            else               hold1 <= rdata_now;
          end
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;
  localparam int ADDR_W = 6;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              req0, we0, ack0, req1, we1, ack1;
  logic [31:0]       addr0, wdata0, rdata0, addr1, wdata1, rdata1;
  logic              mem_en, mem_we, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  // Synchronous RAM with RD_LAT cycles of read latency; junk when not reading.
  logic [31:0] ram [64];
  logic [31:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  // Reference model state
  logic [31:0] model_mem [64];
  logic [31:0] hold_m [2];
  int          model_last;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input logic w);
    return w ? 2 : RD_LAT + 1;
  endfunction

  task automatic model_reset();
    hold_m[0]  = '0;
    hold_m[1]  = '0;
    model_last = 1;
  endtask

  // Drives one single-port transaction and reports what was observed.
  task automatic do_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic en_s, output logic we_s,
                        output logic [ADDR_W-1:0] addr_s, output logic [31:0] wd_s,
                        output logic err_s, output logic [31:0] rd_own, output logic [31:0] rd_oth,
                        output bit stray);
    bit done;
    done = 0; lat = -1; stray = 0;
    en_s = 0; we_s = 0; addr_s = '0; wd_s = '0; err_s = 0; rd_own = '0; rd_oth = '0;
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    for (int n = 1; n <= 20 && !done; n++) begin
      cyc();
      if (n == 1) begin en_s = mem_en; we_s = mem_we; addr_s = mem_addr; wd_s = mem_wdata; end
      if ((p == 0) ? ack1 : ack0) stray = 1;
      if ((p == 0) ? ack0 : ack1) begin
        lat = n; err_s = err; done = 1;
        rd_own = (p == 0) ? rdata0 : rdata1;
        rd_oth = (p == 0) ? rdata1 : rdata0;
      end
    end
    req0 = 0; req1 = 0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 0; req0 = 1; req1 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'h55;
    cyc(); cyc();
    n_checks++;
    if ({ack0, ack1, mem_en, mem_we, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {ack0, ack1, mem_en, mem_we, err});
    end
    n_checks++;
    if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
    n_checks++;
    if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata: got %0h expected 0", mem_wdata); end
    n_checks++;
    if (rdata0 !== '0 || rdata1 !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got %0h/%0h expected 0/0", rdata0, rdata1);
    end
    req0 = 0; req1 = 0; we0 = 0;
    model_reset();
    reset = 1;
    cyc();
  endtask

  task automatic test_cpu_write();
    int lat; logic en, we, e, st; logic [ADDR_W-1:0] ad; logic [31:0] wd, ro, rt;
    bit stray;
    do_txn(0, 1'b1, 32'd100, 32'd7, lat, en, we, ad, wd, e, ro, rt, stray);
    st = stray;
    model_mem[25] = 32'd7; model_last = 0;
    n_checks++;
    if ({en, we} !== 2'b11) begin n_fail++; $display("FAIL wr_strobe: got %b expected 11", {en, we}); end
    n_checks++;
    if (ad !== 6'd25) begin n_fail++; $display("FAIL wr_mem_addr: got %0d expected 25", ad); end
    n_checks++;
    if (wd !== 32'd7) begin n_fail++; $display("FAIL wr_mem_wdata: got %0d expected 7", wd); end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    n_checks++;
    if (st !== 1'b0) begin n_fail++; $display("FAIL wr_ack1_stray: got %b expected 0", st); end
  endtask

  task automatic test_cpu_read();
    int lat; logic en, we, e; logic [ADDR_W-1:0] ad; logic [31:0] wd, ro, rt;
    bit stray;
    do_txn(0, 1'b0, 32'd100, 32'd0, lat, en, we, ad, wd, e, ro, rt, stray);
    n_checks++;
    if (lat !== RD_LAT + 1) begin n_fail++; $display("FAIL rd_latency: got %0d expected %0d", lat, RD_LAT + 1); end
    n_checks++;
    if (ro !== model_mem[25]) begin n_fail++; $display("FAIL rd_data: got %0h expected %0h", ro, model_mem[25]); end
    n_checks++;
    if (rt !== hold_m[1]) begin n_fail++; $display("FAIL rd_other_hold: got %0h expected %0h", rt, hold_m[1]); end
    hold_m[0] = model_mem[25]; model_last = 0;
  endtask

  task automatic test_alternation();
    int ev_p [4]; int ev_t [4]; int nev; bit both;
    logic [31:0] d0, d1;
    reset = 0; cyc(); reset = 1; model_reset();
    d0 = $urandom; d1 = $urandom;
    req0 = 1; we0 = 1; addr0 = 32'd40; wdata0 = d0;
    req1 = 1; we1 = 1; addr1 = 32'd44; wdata1 = d1;
    nev = 0; both = 0;
    for (int n = 1; n <= 20 && nev < 4; n++) begin
      cyc();
      if (ack0 && ack1) both = 1;
      if (ack0) begin ev_p[nev] = 0; ev_t[nev] = n; nev++; end
      else if (ack1) begin ev_p[nev] = 1; ev_t[nev] = n; nev++; end
    end
    req0 = 0; req1 = 0;
    cyc();
    model_mem[10] = d0; model_mem[11] = d1; model_last = 1;
    n_checks++;
    if (nev !== 4) begin n_fail++; $display("FAIL alt_count: got %0d expected 4", nev); end
    for (int k = 0; k < nev; k++) begin
      n_checks++;
      if (ev_p[k] !== (k % 2) || ev_t[k] !== 2 + 3 * k) begin
        n_fail++;
        $display("FAIL alt_txn%0d: got port %0d at %0d expected port %0d at %0d", k, ev_p[k], ev_t[k], k % 2, 2 + 3 * k);
      end
    end
    n_checks++;
    if (both !== 1'b0) begin n_fail++; $display("FAIL alt_dual_ack: got %b expected 0", both); end
  endtask

  task automatic test_addr_change();
    int nack, t_ack; logic [31:0] rd; logic [ADDR_W-1:0] a1, a2;
    req1 = 1; we1 = 0; addr1 = 32'd8;
    cyc();
    a1 = mem_addr;
    addr1 = 32'd12;
    cyc();
    a2 = mem_addr;
    nack = 0; t_ack = -1; rd = '0;
    for (int n = 2; n <= 8; n++) begin
      if (n > 2) cyc();
      if (ack1) begin nack++; t_ack = n; rd = rdata1; req1 = 0; end
    end
    req1 = 0;
    n_checks++;
    if (a1 !== 6'd2 || a2 !== 6'd2) begin n_fail++; $display("FAIL chg_mem_addr: got %0d/%0d expected 2/2", a1, a2); end
    n_checks++;
    if (nack !== 1 || t_ack !== RD_LAT + 1) begin
      n_fail++; $display("FAIL chg_ack: got %0d acks at %0d expected 1 at %0d", nack, t_ack, RD_LAT + 1);
    end
    n_checks++;
    if (rd !== model_mem[2]) begin n_fail++; $display("FAIL chg_rdata: got %0h expected %0h", rd, model_mem[2]); end
    hold_m[1] = model_mem[2]; model_last = 1;
  endtask

  task automatic test_reset_mid();
    int t_ack; logic [31:0] rd;
    req1 = 1; we1 = 0; addr1 = 32'd20;
    cyc(); cyc();
    reset = 0;
    cyc();
    n_checks++;
    if ({ack0, ack1, mem_en, mem_we, err} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0
        || rdata0 !== '0 || rdata1 !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got ctrl %b addr %0h wdata %0h rdata %0h/%0h expected all 0",
               {ack0, ack1, mem_en, mem_we, err}, mem_addr, mem_wdata, rdata0, rdata1);
    end
    reset = 1;
    model_reset();
    t_ack = -1; rd = '0;
    for (int n = 1; n <= 10 && t_ack < 0; n++) begin
      cyc();
      if (ack1) begin t_ack = n; rd = rdata1; end
    end
    req1 = 0;
    cyc();
    n_checks++;
    if (t_ack !== RD_LAT + 1) begin n_fail++; $display("FAIL mid_resume_latency: got %0d expected %0d", t_ack, RD_LAT + 1); end
    n_checks++;
    if (rd !== model_mem[5]) begin n_fail++; $display("FAIL mid_resume_rdata: got %0h expected %0h", rd, model_mem[5]); end
    hold_m[1] = model_mem[5]; model_last = 1;
  endtask

  task automatic test_range();
    int lat; logic en, we, e; logic [ADDR_W-1:0] ad; logic [31:0] wd, ro, rt, d;
    bit stray;
    d = $urandom | 32'h1;
    do_txn(0, 1'b1, 32'h1000, d, lat, en, we, ad, wd, e, ro, rt, stray);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL range_latency: got %0d expected 2", lat); end
`ifdef DMEM_ARB_RANGE_CHK_EN
    n_checks++;
    if ({en, we} !== 2'b00) begin n_fail++; $display("FAIL range_strobe: got %b expected 00", {en, we}); end
    n_checks++;
    if (e !== 1'b1 || ro !== '0) begin n_fail++; $display("FAIL range_err: got err %b rdata %0h expected 1 0", e, ro); end
    hold_m[0] = '0;
`else
    n_checks++;
    if ({en, we} !== 2'b11 || ad !== '0) begin
      n_fail++; $display("FAIL alias_access: got strobe %b addr %0d expected 11 0", {en, we}, ad);
    end
    n_checks++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL alias_err: got %b expected 0", e); end
    model_mem[0] = d;
`endif
    model_last = 0;
  endtask

  task automatic test_random();
    int pat, nsrv, t, p, q;
    logic w [2]; logic [31:0] a [2], d [2]; int idx [2];
    int order [2]; int exp_t [2]; logic [31:0] exp_own [2], exp_oth [2];
    int obs_t [2]; int nack [2]; logic [31:0] obs_own [2], obs_oth [2];
    logic ak [2]; logic [31:0] rdv [2]; bit both;
    for (int it = 0; it < 40; it++) begin
      pat = $urandom_range(1, 3);
      for (int k = 0; k < 2; k++) begin
        w[k] = 1'($urandom_range(0, 1)); idx[k] = $urandom_range(0, 63);
        a[k] = (idx[k] << 2) | $urandom_range(0, 3); d[k] = $urandom;
        obs_t[k] = -1; nack[k] = 0; exp_t[k] = -1; obs_own[k] = '0; obs_oth[k] = '0;
      end
      if (pat == 3) begin order[0] = (model_last == 1) ? 0 : 1; order[1] = 1 - order[0]; nsrv = 2; end
      else begin order[0] = (pat == 1) ? 0 : 1; order[1] = 0; nsrv = 1; end
      t = 0;
      for (int k = 0; k < nsrv; k++) begin
        p = order[k];
        t = (k == 0) ? lat_of(w[p]) : t + 1 + lat_of(w[p]);
        exp_t[p] = t;
        exp_oth[p] = hold_m[1-p];
        if (w[p]) begin model_mem[idx[p]] = d[p]; exp_own[p] = hold_m[p]; end
        else begin exp_own[p] = model_mem[idx[p]]; hold_m[p] = exp_own[p]; end
        model_last = p;
      end
      req0 = (pat & 1) != 0; we0 = w[0]; addr0 = a[0]; wdata0 = d[0];
      req1 = (pat & 2) != 0; we1 = w[1]; addr1 = a[1]; wdata1 = d[1];
      both = 0;
      for (int n = 1; n <= t + 3; n++) begin
        cyc();
        ak[0] = ack0; ak[1] = ack1; rdv[0] = rdata0; rdv[1] = rdata1;
        if (ak[0] && ak[1]) both = 1;
        for (int k = 0; k < 2; k++) begin
          if (ak[k]) begin
            nack[k]++;
            if (obs_t[k] < 0) begin obs_t[k] = n; obs_own[k] = rdv[k]; obs_oth[k] = rdv[1-k]; end
            if (k == 0) req0 = 0; else req1 = 0;
          end
        end
      end
      req0 = 0; req1 = 0;
      for (int k = 0; k < nsrv; k++) begin
        q = order[k];
        n_checks++;
        if (obs_t[q] !== exp_t[q] || nack[q] !== 1) begin
          n_fail++;
          $display("FAIL rnd%0d_ack_p%0d: got %0d acks first at %0d expected 1 at %0d", it, q, nack[q], obs_t[q], exp_t[q]);
        end
        n_checks++;
        if (obs_own[q] !== exp_own[q] || obs_oth[q] !== exp_oth[q]) begin
          n_fail++;
          $display("FAIL rnd%0d_rdata_p%0d: got %0h/%0h expected %0h/%0h", it, q, obs_own[q], obs_oth[q], exp_own[q], exp_oth[q]);
        end
      end
      n_checks++;
      if (both !== 1'b0 || (nsrv == 1 && nack[1-order[0]] !== 0)) begin
        n_fail++; $display("FAIL rnd%0d_stray_ack: got dual %b idle-port acks %0d expected 0 0", it, both, nack[1-order[0]]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin ram[i] = '0; model_mem[i] = '0; end
    reset = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    model_reset();
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_alternation();
    test_addr_change();
    test_reset_mid();
    test_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter sharing the single-port data memory between the ARMv4 core's data port (requester 0) and a loader/debug port (requester 1).
- Per-port req/ack handshake; one memory transaction at a time.
- Round-robin arbitration.
- Read-data latency matched to the synchronous RAM.
- Sits between top's datapath and the data memory instance.

Parameters:
ADDR_W, 6, word-address width driven to memory (64 words)
RD_LAT, 1, memory read latency in cycles (1..3)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets)
req0  in  1  requester 0 (CPU) request; held until ack0
we0  in  1  requester 0 write enable
addr0  in  32  requester 0 byte address
wdata0  in  32  requester 0 write data
rdata0  out  32  requester 0 read data, valid when ack0=1
ack0  out  1  requester 0 completion pulse
req1, we1, addr1, wdata1, rdata1, ack1  (same widths/meaning) for requester 1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  word address = latched addr[ADDR_W+1:2]
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid RD_LAT cycles after mem_en
err  out  1  range-error pulse (only with optional feature)

Behaviour:
- Reset (reset==0 at rising edge):
  - state=IDLE, last=1 (so requester 0 wins the first tie).
  - All outputs 0: ack0/1, mem_en, mem_we, rdata0/1, mem_addr, mem_wdata, err.
  - Reset mid-transaction aborts it: no ack issued; a pending write not yet strobed is dropped.
- FSM:
  - IDLE:
    - Only one req high: grant it.
    - Both high: grant !last.
    - Grant latches owner, we, addr, wdata -> ACCESS.
  - ACCESS (1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latches.
    - Write -> RESP.
    - Read -> WAIT with counter=RD_LAT-1; RD_LAT=1 goes straight to RESP.
  - WAIT: decrement counter; at 0 -> RESP.
  - RESP (1 cycle): ack[owner]=1.
    - Read: rdata[owner]=mem_rdata captured this cycle.
    - last=owner -> IDLE.
- Latency from req sampled in IDLE to ack:
  - Write: 2 cycles.
  - Read: RD_LAT+1 cycles.
  - Next grant earliest 1 cycle after ack.
- Request/command changes after the grant are ignored until the next IDLE.
- Requester must drop req the cycle after ack, or it is treated as a new request.
- rdata of the non-owner holds its previous value.
- addr[1:0] ignored (word aligned); addr bits above ADDR_W+1 ignored unless the optional feature is on.
- req asserted during RESP is not sampled until IDLE.
- ack is never asserted to both ports in the same cycle.

Optional Feature:
DMEM_ARB_RANGE_CHK_EN
- Defined:
  - If any latched addr bit [31:ADDR_W+2] is nonzero, ACCESS drives mem_en=0 and mem_we=0.
  - FSM goes to RESP with ack[owner]=1, rdata=0 and err=1 for that cycle.
- Undefined: err tied 0; upper address bits ignored (address aliasing).

Decomposition:
- Package dmem_arb_pkg:
  - State enum (IDLE, ACCESS, WAIT, RESP).
  - Owner typedef (1 bit).
  - Localparam WORD_W=32.
- Sub-module rr_arb2: combinational 2-way round-robin picker (inputs req0, req1, last; output grant index, valid).
- FSM and latches stay in dmem_arbiter.

Test Plan:
- CPU write only: req0, we0=1, addr0=100, wdata0=7 -> mem_en=mem_we=1, mem_addr=25, mem_wdata=7 one cycle later; ack0 two cycles after req sampled; ack1 stays 0.
- CPU read with RD_LAT=2, memory word 25 = 7: read addr0=100 -> ack0 on cycle 3 with rdata0=7; rdata1 unchanged.
- Simultaneous req0 and req1 from reset -> requester 0 served first. Then requester 1, since req0 is held with a new request. Then requester 0 again: strict alternation over 4 transactions.
- Reset driven low during WAIT -> next cycle all outputs 0, no ack. After release, a pending req1 is served normally.
- Requester changes addr1 from 8 to 12 mid-transaction -> mem_addr=2 (latched value); ack1 issued once.
- DMEM_ARB_RANGE_CHK_EN defined, write addr0=0x1000 -> mem_en stays 0, ack0=1 and err=1 same cycle. Without the macro, the same write hits mem_addr=0 with err=0.
